// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the CPU sequencer and its RAM / datapath neighbours.
// master = sequencer side, slave = RAM/datapath (or bench) side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [31:0]     ram_out;
  logic [15:0]     mem_addr;
  logic [3:0]      alu_flag;
  logic            ram_enable;
  logic            ram_rw;
  logic [15:0]     ram_address;
  logic [31:0]     instr;
  logic [3:0]      flag;
  logic            reg_write;
  logic            load_sel;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;

  modport master (
    input  start, ram_out, mem_addr, alu_flag,
    output ram_enable, ram_rw, ram_address, instr, flag,
           reg_write, load_sel, pc, busy, halted
  );

  modport slave (
    output start, ram_out, mem_addr, alu_flag,
    input  ram_enable, ram_rw, ram_address, instr, flag,
           reg_write, load_sel, pc, busy, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the single-RAM CPU: owns PC, IR and flags.
// Instruction fields: Cond=[31:28], OpCode=[24:21], S=[20].
module cpu_sequencer #(
  parameter int         PC_W   = 8,
  parameter logic [3:0] LDR_OP = 4'b1101,
  parameter logic [3:0] STR_OP = 4'b1110,
  parameter logic [3:0] HLT_OP = 4'b1111
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cpu_sequencer_if.master   io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc;
  logic [31:0]     r_instr, w_instr_next;
  logic [3:0]      r_flag, w_flag_next;
  logic [15:0]     r_ram_address, w_ram_address_next;

  logic [3:0] w_cond, w_opcode;
  logic       w_s, w_n, w_z, w_c, w_v;
  logic       w_cond_true, w_is_ldr, w_is_str;

  assign w_cond   = r_instr[31:28];
  assign w_opcode = r_instr[24:21];
  assign w_s      = r_instr[20];
  assign {w_n, w_z, w_c, w_v} = r_flag;
  assign w_is_ldr = (w_opcode == LDR_OP);
  assign w_is_str = (w_opcode == STR_OP);
  assign w_pc_inc = r_pc + PC_W'(1);

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      4'b0000: w_cond_true = w_z;
      4'b0001: w_cond_true = !w_z;
      4'b0010: w_cond_true = w_c;
      4'b0011: w_cond_true = !w_c;
      4'b0100: w_cond_true = w_n;
      4'b0101: w_cond_true = !w_n;
      4'b0110: w_cond_true = w_v;
      4'b0111: w_cond_true = !w_v;
      4'b1010: w_cond_true = (w_n == w_v);
      4'b1011: w_cond_true = (w_n != w_v);
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Ram_Address is reloaded with the next PC on every path back to FETCH.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_flag_next        = r_flag;
    w_ram_address_next = r_ram_address;
    case (r_state)
      S_IDLE: begin
        w_ram_address_next = 16'(r_pc);
        if (io_bus.start) w_state_next = S_FETCH;
      end
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        w_instr_next = io_bus.ram_out;
        w_state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (!w_cond_true) begin
          w_pc_next          = w_pc_inc;
          w_ram_address_next = 16'(w_pc_inc);
          w_state_next       = S_FETCH;
        end else if (w_opcode == HLT_OP) begin
          w_state_next = S_HALT;
        end else if (w_is_ldr || w_is_str) begin
          w_ram_address_next = io_bus.mem_addr;
          w_state_next       = S_MEM;
        end else begin
          if (w_s) w_flag_next = io_bus.alu_flag;
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_is_str) begin
          w_pc_next          = w_pc_inc;
          w_ram_address_next = 16'(w_pc_inc);
          w_state_next       = S_FETCH;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_WB: begin
        w_pc_next          = w_pc_inc;
        w_ram_address_next = 16'(w_pc_inc);
        w_state_next       = S_FETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_instr       <= '0;
      r_flag        <= '0;
      r_ram_address <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_flag        <= w_flag_next;
      r_ram_address <= w_ram_address_next;
    end
  end

  // Strobes decode from the state register only, so reset clears them at once.
  assign io_bus.ram_enable  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign io_bus.ram_rw      = !((r_state == S_MEM) && w_is_str);
  assign io_bus.ram_address = r_ram_address;
  assign io_bus.instr       = r_instr;
  assign io_bus.flag        = r_flag;
  assign io_bus.reg_write   = (r_state == S_WB);
  assign io_bus.load_sel    = (r_state == S_WB) && w_is_ldr;
  assign io_bus.pc          = r_pc;
  assign io_bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign io_bus.halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, corner sequences,
// and a randomized program checked against an instruction-level model.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam logic [3:0] LDR = 4'b1101, STR = 4'b1110, HLT = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(8)) bus8 ();
  cpu_sequencer_if #(.PC_W(2)) bus2 ();

  cpu_sequencer #(.PC_W(8)) dut  (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus8));
  cpu_sequencer #(.PC_W(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2));

  logic [31:0] mem  [0:65535];
  logic [31:0] mem2 [0:3];

  // Synchronous-read RAM: data appears the cycle after the request.
  always @(posedge clk) begin
    if (bus8.ram_enable && bus8.ram_rw) bus8.ram_out <= mem[bus8.ram_address];
    if (bus2.ram_enable && bus2.ram_rw) bus2.ram_out <= mem2[bus2.ram_address[1:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int         cycles;
    int         writes;
    bit         load;
    bit         store;
    logic [3:0] flag;
    bit         halt;
  } expect_t;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] maddr;
    logic [3:0]  alu;
    expect_t     e;
  } vec_t;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input bit s);
    return {c, 3'b000, op, s, 20'h5A5A5};
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level model: outcome of one whole instruction.
  function automatic expect_t predict(input logic [31:0] ins, input logic [3:0] f, input logic [3:0] alu);
    expect_t e;
    logic [3:0] op;
    op = ins[24:21];
    e.flag = f; e.writes = 0; e.load = 0; e.store = 0; e.halt = 0; e.cycles = 3;
    if (!cond_holds(ins[31:28], f)) e.cycles = 3;
    else if (op == HLT) e.halt = 1;
    else if (op == LDR) begin e.cycles = 5; e.writes = 1; e.load = 1; end
    else if (op == STR) begin e.cycles = 4; e.store = 1; end
    else begin
      e.cycles = 4; e.writes = 1;
      if (ins[20]) e.flag = alu;
    end
    return e;
  endfunction

  // Entered at the negedge inside the FETCH cycle of the instruction at pc.
  task automatic run_instr(input string tag, input int pc, input logic [31:0] ins,
                           input logic [15:0] maddr, input logic [3:0] alu, input expect_t e);
    int rd = 0, wr = 0, nw = 0, not_busy = 0, npc;
    logic ls = 1'b0;
    logic [15:0] rd_a = '0, wr_a = '0;
    logic [31:0] wd = '0;
    bus8.mem_addr = maddr;
    bus8.alu_flag = alu;
    check({tag, ".fetch_en"}, bus8.ram_enable, 1);
    check({tag, ".fetch_rw"}, bus8.ram_rw, 1);
    check({tag, ".fetch_addr"}, bus8.ram_address, pc);
    for (int i = 1; i < e.cycles; i++) begin
      @(negedge clk);
      if (i == 2) check({tag, ".instr"}, bus8.instr, ins);
      if (bus8.ram_enable && bus8.ram_rw) begin rd++; rd_a = bus8.ram_address; end
      if (bus8.ram_enable && !bus8.ram_rw) begin wr++; wr_a = bus8.ram_address; end
      if (bus8.reg_write) begin nw++; ls = bus8.load_sel; wd = bus8.ram_out; end
      if (!bus8.busy) not_busy++;
    end
    @(negedge clk);
    npc = e.halt ? pc : (pc + 1) % 256;
    check({tag, ".pc"}, bus8.pc, npc);
    check({tag, ".halted"}, bus8.halted, e.halt);
    if (e.halt) begin
      check({tag, ".halt_en"}, bus8.ram_enable, 0);
      check({tag, ".halt_busy"}, bus8.busy, 0);
    end else begin
      check({tag, ".next_fetch"}, {bus8.ram_enable, bus8.ram_rw}, 2'b11);
      check({tag, ".next_addr"}, bus8.ram_address, npc);
    end
    check({tag, ".flag"}, bus8.flag, e.flag);
    check({tag, ".reg_writes"}, nw, e.writes);
    if (e.writes > 0) check({tag, ".load_sel"}, ls, e.load);
    check({tag, ".data_reads"}, rd, e.load ? 1 : 0);
    check({tag, ".data_writes"}, wr, e.store ? 1 : 0);
    if (e.load) begin
      check({tag, ".ld_addr"}, rd_a, maddr);
      check({tag, ".ld_data"}, wd, mem[maddr]);
    end
    if (e.store) check({tag, ".st_addr"}, wr_a, maddr);
    check({tag, ".busy"}, not_busy, 0);
    $display("[%0t] %s pc=%0d instr=%h cycles=%0d writes=%0d load=%0d store=%0d halt=%0d flag=%b",
             $time, tag, pc, ins, e.cycles, e.writes, e.load, e.store, e.halt, e.flag);
  endtask

  task automatic pulse_start8();
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  vec_t tbl [18];

  initial begin
    int en_seen;
    logic [3:0] mflag;
    int pc;

    bus8.start = 0; bus8.mem_addr = '0; bus8.alu_flag = '0;
    bus2.start = 0; bus2.mem_addr = '0; bus2.alu_flag = '0;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int a = 0; a < 4; a++) mem2[a] = mk(4'hE, 4'h4, 1'b0);

    // Reset state, during and after reset with Start low.
    repeat (3) @(negedge clk);
    check("rst.busy_during", bus8.busy, 0);
    check("rst.reg_write_during", bus8.reg_write, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle.pc", bus8.pc, 0);
    check("idle.en", bus8.ram_enable, 0);
    check("idle.rw", bus8.ram_rw, 1);
    check("idle.busy", bus8.busy, 0);
    check("idle.halted", bus8.halted, 0);
    check("idle.instr", bus8.instr, 0);
    check("idle.flag", bus8.flag, 0);
    check("idle.addr", bus8.ram_address, 0);
    check("idle.reg_write", bus8.reg_write, 0);
    check("idle.load_sel", bus8.load_sel, 0);

    // Directed program: {instr, Mem_Addr, Alu_Flag, {cycles, writes, load, store, flag, halt}}
    tbl[0]  = '{mk(4'hE, 4'h4, 1), 16'h0000, 4'b0100, '{4, 1, 0, 0, 4'b0100, 0}};
    tbl[1]  = '{mk(4'h1, 4'h4, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0100, 0}};
    tbl[2]  = '{mk(4'h0, 4'h2, 0), 16'h0000, 4'b1111, '{4, 1, 0, 0, 4'b0100, 0}};
    tbl[3]  = '{mk(4'hE, LDR,  1), 16'h0040, 4'b1111, '{5, 1, 1, 0, 4'b0100, 0}};
    tbl[4]  = '{mk(4'hE, STR,  1), 16'h0041, 4'b1111, '{4, 0, 0, 1, 4'b0100, 0}};
    tbl[5]  = '{mk(4'h8, 4'h4, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0100, 0}};
    tbl[6]  = '{mk(4'hC, 4'h4, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0100, 0}};
    tbl[7]  = '{mk(4'hE, 4'h0, 1), 16'h0000, 4'b1001, '{4, 1, 0, 0, 4'b1001, 0}};
    tbl[8]  = '{mk(4'hA, 4'h3, 1), 16'h0000, 4'b0010, '{4, 1, 0, 0, 4'b0010, 0}};
    tbl[9]  = '{mk(4'hB, 4'h3, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0010, 0}};
    tbl[10] = '{mk(4'h2, 4'h3, 0), 16'h0000, 4'b1111, '{4, 1, 0, 0, 4'b0010, 0}};
    tbl[11] = '{mk(4'h3, 4'h3, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0010, 0}};
    tbl[12] = '{mk(4'h4, 4'h3, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0010, 0}};
    tbl[13] = '{mk(4'h5, 4'h3, 1), 16'h0000, 4'b0001, '{4, 1, 0, 0, 4'b0001, 0}};
    tbl[14] = '{mk(4'h6, 4'h3, 0), 16'h0000, 4'b1111, '{4, 1, 0, 0, 4'b0001, 0}};
    tbl[15] = '{mk(4'h7, 4'h3, 1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0001, 0}};
    tbl[16] = '{mk(4'hF, HLT,  1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0001, 0}};
    tbl[17] = '{mk(4'hE, HLT,  1), 16'h0000, 4'b1111, '{3, 0, 0, 0, 4'b0001, 1}};
    for (int i = 0; i < 18; i++) mem[i] = tbl[i].instr;
    mem[16'h0040] = 32'hDEADBEEF;

    pulse_start8();
    for (int i = 0; i < 18; i++)
      run_instr($sformatf("tbl%0d", i), i, tbl[i].instr, tbl[i].maddr, tbl[i].alu, tbl[i].e);

    // HALT is sticky: Start pulses are ignored.
    pulse_start8();
    repeat (4) @(negedge clk);
    check("halt.sticky", bus8.halted, 1);
    check("halt.pc", bus8.pc, 17);
    check("halt.en", bus8.ram_enable, 0);
    check("halt.busy", bus8.busy, 0);
    $display("[%0t] halt hold pc=%0d halted=%0d", $time, bus8.pc, bus8.halted);

    // Reset during the WB cycle of an LDR.
    rst_n = 1'b0;
    mem[0] = mk(4'hE, LDR, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus8.mem_addr = 16'h0040;
    @(negedge clk);
    pulse_start8();
    repeat (4) @(negedge clk);
    check("ldr_wb.reg_write", bus8.reg_write, 1);
    check("ldr_wb.load_sel", bus8.load_sel, 1);
    check("ldr_wb.ram_out", bus8.ram_out, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("abort.reg_write", bus8.reg_write, 0);
    check("abort.load_sel", bus8.load_sel, 0);
    check("abort.pc", bus8.pc, 0);
    check("abort.busy", bus8.busy, 0);
    check("abort.en", bus8.ram_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.ram_enable || bus8.reg_write || bus8.busy) en_seen++;
    end
    check("abort.quiet", en_seen, 0);
    $display("[%0t] reset-abort activity_after=%0d", $time, en_seen);

    // Randomized program against the instruction-level model.
    rst_n = 1'b0;
    for (int a = 0; a < 256; a++) begin
      logic [3:0] c, op;
      c  = 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      if (op == HLT && !(c == 4'h8 || c == 4'h9 || c == 4'hC || c == 4'hD || c == 4'hF)) op = LDR;
      mem[a] = {c, 3'($urandom), op, 21'($urandom)};
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start8();
    mflag = 4'b0000;
    pc = 0;
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ma;
      logic [3:0] al;
      expect_t e;
      ma = 16'($urandom);
      al = 4'($urandom);
      e  = predict(mem[pc], mflag, al);
      run_instr($sformatf("rnd%0d", k), pc, mem[pc], ma, al, e);
      mflag = e.flag;
      pc = (pc + 1) % 256;
    end

    // PC_W=2 instance: wrap 3 -> 0, then halt at address 2.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wrap%0d.pc", i), bus2.pc, i % 4);
      check($sformatf("wrap%0d.addr", i), bus2.ram_address, i % 4);
      $display("[%0t] wrap step %0d pc=%0d", $time, i, bus2.pc);
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    mem2[2] = mk(4'hE, HLT, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (11) @(negedge clk);
    check("w2halt.halted", bus2.halted, 1);
    check("w2halt.pc", bus2.pc, 2);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (4) @(negedge clk);
    check("w2halt.sticky", bus2.halted, 1);
    check("w2halt.pc_hold", bus2.pc, 2);
    $display("[%0t] pc2 halt pc=%0d halted=%0d", $time, bus2.pc, bus2.halted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the single-RAM CPU. It owns the program counter, instruction register and status-flag register. It sequences the shared RAM port between instruction fetch and LDR/STR data access, and gates register-bank writeback with the instruction's condition field. It sits between the RAM, memory_control, Register_bank and MASTER_ALU, replacing bench-driven addressing.

Parameters:
PC_W, 8, program counter width; PC wraps from 2^PC_W-1 to 0
LDR_OP, 4'b1101, OpCode value for load
STR_OP, 4'b1110, OpCode value for store
HLT_OP, 4'b1111, OpCode value for halt

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  leave IDLE and begin fetching at PC=0
Ram_Out  input  32  RAM read data (instruction or load data), valid the cycle after a read request
Mem_Addr  input  16  data address from memory_control, sampled in EXECUTE
Alu_Flag  input  4  ALU New_Flag {N,Z,C,V}, sampled in EXECUTE
Ram_Enable  output  1  RAM access strobe
Ram_RW  output  1  1=read, 0=write
Ram_Address  output  16  RAM address
Instr  output  32  instruction register; drives Cond/OpCode/S/fields
Flag  output  4  registered status flags {N,Z,C,V} to ALU
Reg_Write  output  1  one-cycle register-bank write strobe
Load_Sel  output  1  1 = writeback data from RAM, 0 = from ALU (valid with Reg_Write)
PC  output  PC_W  program counter
Busy  output  1  high in every state except IDLE and HALT
Halted  output  1  high in HALT

Behaviour:
- Reset (Reset=0, async): state=IDLE; PC=0, Instr=0, Flag=0, Ram_Address=0, Ram_Enable=0, Ram_RW=1, Reg_Write=0, Load_Sel=0, Busy=0, Halted=0.
- Outputs are registered or decoded from state only. There is no combinational input-to-output path.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- IDLE: wait for Start=1, then go to FETCH. Start is ignored in all other states.
- FETCH: Ram_Enable=1, Ram_RW=1, Ram_Address={0,PC}. Next state DECODE.
- DECODE: Instr<=Ram_Out. Next state EXECUTE.
- EXECUTE: evaluate Cond against Flag:
  - 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1010 N==V, 1011 N!=V, 1110 always.
  - All other Cond values are never-execute.
- EXECUTE, condition false: PC<=PC+1, go to FETCH. No write, no flag change; 3 cycles total.
- EXECUTE, OpCode==HLT_OP with condition true: go to HALT. PC is not incremented.
- EXECUTE, LDR_OP or STR_OP: latch Mem_Addr into Ram_Address, go to MEM.
- EXECUTE, any other opcode: if S=1 then Flag<=Alu_Flag. Go to WB.
- MEM, LDR: Ram_Enable=1, Ram_RW=1. Go to WB with Load_Sel=1.
- MEM, STR: Ram_Enable=1, Ram_RW=0 for exactly one cycle. PC<=PC+1, go to FETCH; 4 cycles total.
- WB: Reg_Write=1 for one cycle; Load_Sel=1 for LDR, else 0. PC<=PC+1, go to FETCH.
  - ALU instruction: 4 cycles. LDR: 5 cycles.
- LDR/STR never update Flag, regardless of S.
- Ram_Enable=0 in IDLE, DECODE, EXECUTE, WB and HALT. Ram_RW=1 whenever not writing.
- HALT: Halted=1, Busy=0, all strobes low. Only Reset exits HALT.
- PC increment wraps modulo 2^PC_W. Fetch of address 2^PC_W-1 followed by a non-halt instruction gives PC=0.
- Reset asserted mid-instruction aborts immediately. No partial Reg_Write or RAM write may occur after the reset edge.

Test Plan:
1. Reset low, then high with Start=0 for 10 cycles -> state IDLE, PC=0, Ram_Enable=0, Busy=0, Ram_RW=1.
2. RAM[0]=AL ALU op S=1, Alu_Flag=4'b0100; pulse Start -> Ram_Address=0 in FETCH, Instr=RAM[0] after DECODE, Flag=0100 after EXECUTE, single Reg_Write pulse, PC=1 exactly 4 cycles after the first FETCH.
3. Flag Z=1; RAM[1]=NE (0001) ALU op -> no Reg_Write, Flag unchanged, PC=2 after 3 cycles. Repeat with EQ (0000) -> Reg_Write asserted.
4. LDR with Mem_Addr=16'h0040, RAM[0x40]=32'hDEADBEEF -> MEM cycle shows Ram_Address=0x40 with Ram_RW=1; WB shows Reg_Write=1, Load_Sel=1, Ram_Out=DEADBEEF. STR to 0x41 -> one cycle Ram_Enable=1, Ram_RW=0, no Reg_Write, 4-cycle instruction.
5. PC_W=2 with RAM[0..3] all AL ALU ops -> PC sequence 0,1,2,3,0. HLT_OP at address 2 -> Halted=1, PC stays 2, Start pulses ignored.
6. Assert Reset during the WB cycle of an LDR -> Reg_Write falls asynchronously, PC=0, state IDLE, no further RAM access until Start.
